decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter MULT_LAT, default 4, legal 1..15: cycles after a mult issues before mfhi/mflo may issue.
REQ-002 Parameter HAZARD_EN, default 1: 1 enables the load-use interlock; 0 removes it, and in_ready then ignores load-use conditions.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid / in_ready  input / output  1 / 1  fetch-side handshake; transfer occurs when both are 1.
REQ-006 in_instr  input  32  instruction word.
REQ-007 flush  input  1  branch/jump redirect; discards the held instruction.
REQ-008 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-009 out_memtoreg, out_memwrite, out_alusrcbimm, out_jump, out_jr, out_beq, out_bltz  output  1 each  decoded controls.
REQ-010 out_regwrite  output  2  00 none, 01 ALU/memory result, 10 link (PC+4).
REQ-011 out_destreg, out_rs, out_rt  output  5 each  register numbers.
REQ-012 out_alucontrol  output  4  ALU operation code.
REQ-013 out_illegal  output  1  unrecognised opcode or funct.
REQ-014 mult_busy  output  1  multiply latency counter is non-zero.

Function
REQ-015 The block SHALL hold one registered output slot; decoded fields SHALL appear on outputs the cycle after acceptance, giving 1-cycle latency.
REQ-016 in_ready SHALL equal (~out_valid | out_ready) & ~flush & ~stall, where stall is the OR of the interlocks in REQ-020 and REQ-021.
REQ-017 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-018 Decode SHALL map as follows:
- addu 0010, subu 0110, and 0000, or 0001, sltu 1110, mfhi 1100, mflo 1010, mult 0111.
- lw/sw: 0010 with alusrcbimm=1.
- beq: 0110. bltz: 1110. addiu: 0010. ori: 0001. lui: 1000.
- j, jal, jr: alucontrol 1111.
REQ-019 Register-field rules:
- destreg: rd for R-type, rt for I-type, 31 for jal.
- regwrite=00 for sw, beq, bltz, j, jr and mult.
- An unknown op or funct SHALL set out_illegal=1 and drive every write-enable and jump/branch control to 0, never X.
REQ-020 Load-use interlock (HAZARD_EN=1):
- The stall condition holds when the slot holds a valid lw with destreg≠0, and in_instr rs or rt equals that destreg.
- While it holds, the block SHALL deassert in_ready until the lw leaves the slot, then insert exactly one bubble cycle with out_valid=0.
REQ-021 Multiply interlock:
- A mult handshake on the output SHALL load the counter with MULT_LAT.
- The counter SHALL decrement each cycle down to 0.
- An incoming mfhi, mflo or mult SHALL stall while the counter is non-zero.
REQ-022 flush SHALL clear out_valid and the pending bubble on the next edge, and SHALL take priority over acceptance in the same cycle.
- flush SHALL NOT clear the multiply counter.
REQ-023 A mult issue and a counter reaching 0 in the same cycle SHALL result in the reload value MULT_LAT.

Reset
REQ-024 While reset_n=0 the block SHALL force these values regardless of clk:
- out_valid=0, mult counter=0, bubble=0, mult_busy=0.
- All decoded outputs to 0, with out_alucontrol=1111.
REQ-025 in_ready SHALL be 1 during the first cycle after reset release.
REQ-026 Reset asserted mid-stall SHALL discard the slot contents and all interlock state.

Structure
REQ-027 A shared package SHALL hold the opcode/funct constants, the ALU code constants, and the regwrite encoding enum.
REQ-028 One sub-module, decode_comb, SHALL hold the purely combinational instruction-to-control mapping; decode_stage SHALL instantiate it and own all state.

Verification
REQ-029 Scenario 1: addu $3,$1,$2 with out_ready=1 → next cycle out_valid=1, alucontrol=0010, destreg=3, regwrite=01.
REQ-030 Scenario 2: lw $5,0($4), then addu $6,$5,$1 → exactly one bubble cycle with out_valid=0 between the two; repeated with $0 as destination → no bubble.
REQ-031 Scenario 3: MULT_LAT=4, mult then mflo back-to-back → mflo issues 4 cycles after mult, and mult_busy is high for exactly those 4 cycles.
REQ-032 Scenario 4: out_ready=0 for 3 cycles while valid → outputs unchanged and in_ready=0; a new instruction offered is not lost.
REQ-033 Scenario 5: flush asserted together with in_valid → instruction dropped, out_valid=0 next cycle, mult counter unaffected.
REQ-034 Scenario 6: opcode 6'b111111, then reset_n pulsed low mid-stall → out_illegal=1 with regwrite=00 and memwrite=0; after reset all outputs are at their reset values and in_ready=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared encodings for the decode stage: MIPS opcode/funct values, ALU operation
// codes, the regwrite encoding and the decoded-control bundle.
package decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_MULT = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_MFLO = 4'b1010;
  localparam logic [3:0] ALU_MFHI = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1110;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  typedef enum logic [1:0] {
    RW_NONE   = 2'b00,
    RW_RESULT = 2'b01,
    RW_LINK   = 2'b10
  } regwrite_e;

  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic       alusrcbimm;
    logic       jump;
    logic       jr;
    logic       beq;
    logic       bltz;
    regwrite_e  regwrite;
    logic [4:0] destreg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [3:0] alucontrol;
    logic       illegal;
  } ctrl_t;

  // Idle value of the bundle: everything off, ALU code "no operation".
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c            = '0;
    c.regwrite   = RW_NONE;
    c.alucontrol = ALU_NONE;
    return c;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction-word to control-bundle mapping.
module decode_comb
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        is_mult,
  output logic        uses_mult
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] shamt;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign shamt = instr[10:6];

  always_comb begin
    ctrl      = ctrl_reset();
    ctrl.rs   = instr[25:21];
    ctrl.rt   = instr[20:16];
    is_mult   = 1'b0;
    uses_mult = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.destreg  = instr[15:11];
        ctrl.regwrite = RW_RESULT;
        case (funct)
          FN_ADDU: ctrl.alucontrol = ALU_ADD;
          FN_SUBU: ctrl.alucontrol = ALU_SUB;
          FN_AND:  ctrl.alucontrol = ALU_AND;
          FN_OR:   ctrl.alucontrol = ALU_OR;
          FN_SLTU: ctrl.alucontrol = ALU_SLTU;
          FN_MFHI: begin
            ctrl.alucontrol = ALU_MFHI;
            uses_mult       = 1'b1;
          end
          FN_MFLO: begin
            ctrl.alucontrol = ALU_MFLO;
            uses_mult       = 1'b1;
          end
          FN_MULT: begin
            ctrl.alucontrol = ALU_MULT;
            ctrl.regwrite   = RW_NONE;
            is_mult         = 1'b1;
            uses_mult       = 1'b1;
          end
          FN_JR: begin
            ctrl.jr       = 1'b1;
            ctrl.regwrite = RW_NONE;
          end
          default: begin
            ctrl.illegal  = 1'b1;
            ctrl.regwrite = RW_NONE;
          end
        endcase
        // None of the supported R-type ops use a shift amount.
        if (shamt != 5'd0) begin
          ctrl          = ctrl_reset();
          ctrl.rs       = instr[25:21];
          ctrl.rt       = instr[20:16];
          ctrl.destreg  = instr[15:11];
          ctrl.illegal  = 1'b1;
          is_mult       = 1'b0;
          uses_mult     = 1'b0;
        end
      end
      OP_LW: begin
        ctrl.destreg    = instr[20:16];
        ctrl.memtoreg   = 1'b1;
        ctrl.alusrcbimm = 1'b1;
        ctrl.regwrite   = RW_RESULT;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        ctrl.destreg    = instr[20:16];
        ctrl.memwrite   = 1'b1;
        ctrl.alusrcbimm = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.destreg    = instr[20:16];
        ctrl.beq        = 1'b1;
        ctrl.alucontrol = ALU_SUB;
      end
      OP_REGIMM: begin
        ctrl.destreg    = instr[20:16];
        ctrl.bltz       = 1'b1;
        ctrl.alucontrol = ALU_SLTU;
      end
      OP_ADDIU, OP_ORI, OP_LUI: begin
        ctrl.destreg    = instr[20:16];
        ctrl.alusrcbimm = 1'b1;
        ctrl.regwrite   = RW_RESULT;
        ctrl.alucontrol = (op == OP_ADDIU) ? ALU_ADD : (op == OP_ORI) ? ALU_OR : ALU_LUI;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.destreg  = 5'd31;
        ctrl.regwrite = RW_LINK;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Single-slot registered decode stage with ready/valid handshakes, a load-use
// interlock and a multiply-latency interlock.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned MULT_LAT  = 4,
  parameter int unsigned HAZARD_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_memtoreg,
  output logic        out_memwrite,
  output logic        out_alusrcbimm,
  output logic        out_jump,
  output logic        out_jr,
  output logic        out_beq,
  output logic        out_bltz,
  output logic [1:0]  out_regwrite,
  output logic [4:0]  out_destreg,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [3:0]  out_alucontrol,
  output logic        out_illegal,
  output logic        mult_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT);

  ctrl_t      in_ctrl;
  logic       in_is_mult;
  logic       in_uses_mult;
  ctrl_t      slot_reg;
  logic       slot_mult_reg;
  logic       valid_reg;
  logic [3:0] mult_cnt_reg;
  logic       load_use;
  logic       mult_stall;
  logic       accept;
  logic       out_fire;

  decode_comb u_decode (
    .instr     (in_instr),
    .ctrl      (in_ctrl),
    .is_mult   (in_is_mult),
    .uses_mult (in_uses_mult)
  );

  // The stalled cycle keeps the slot empty once the lw leaves, which is the bubble.
  assign load_use = (HAZARD_EN != 0) && valid_reg && slot_reg.memtoreg &&
                    (slot_reg.destreg != 5'd0) &&
                    ((in_ctrl.rs == slot_reg.destreg) || (in_ctrl.rt == slot_reg.destreg));

  // A mult still waiting in the slot has not loaded the counter yet, so it blocks too.
  assign mult_stall = in_uses_mult && ((mult_cnt_reg != 4'd0) || (valid_reg && slot_mult_reg));

  assign in_ready = (~valid_reg | out_ready) & ~flush & ~(load_use | mult_stall);
  assign accept   = in_valid & in_ready;
  assign out_fire = valid_reg & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg     <= 1'b0;
      slot_reg      <= ctrl_reset();
      slot_mult_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg     <= 1'b1;
      slot_reg      <= in_ctrl;
      slot_mult_reg <= in_is_mult;
    end else if (out_fire) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mult_cnt_reg <= 4'd0;
    end else if (out_fire && slot_mult_reg) begin
      mult_cnt_reg <= MULT_LOAD;
    end else if (mult_cnt_reg != 4'd0) begin
      mult_cnt_reg <= mult_cnt_reg - 4'd1;
    end
  end

  assign out_valid      = valid_reg;
  assign out_memtoreg   = slot_reg.memtoreg;
  assign out_memwrite   = slot_reg.memwrite;
  assign out_alusrcbimm = slot_reg.alusrcbimm;
  assign out_jump       = slot_reg.jump;
  assign out_jr         = slot_reg.jr;
  assign out_beq        = slot_reg.beq;
  assign out_bltz       = slot_reg.bltz;
  assign out_regwrite   = slot_reg.regwrite;
  assign out_destreg    = slot_reg.destreg;
  assign out_rs         = slot_reg.rs;
  assign out_rt         = slot_reg.rt;
  assign out_alucontrol = slot_reg.alucontrol;
  assign out_illegal    = slot_reg.illegal;
  assign mult_busy      = (mult_cnt_reg != 4'd0);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, interlocks, backpressure,
// flush and asynchronous reset.
module tb_decode_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_memtoreg, out_memwrite, out_alusrcbimm, out_jump, out_jr, out_beq, out_bltz;
  logic [1:0]  out_regwrite;
  logic [4:0]  out_destreg, out_rs, out_rt;
  logic [3:0]  out_alucontrol;
  logic        out_illegal;
  logic        mult_busy;

  int total = 0;
  int bad   = 0;

  decode_stage #(.MULT_LAT(4), .HAZARD_EN(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_memtoreg   (out_memtoreg),
    .out_memwrite   (out_memwrite),
    .out_alusrcbimm (out_alusrcbimm),
    .out_jump       (out_jump),
    .out_jr         (out_jr),
    .out_beq        (out_beq),
    .out_bltz       (out_bltz),
    .out_regwrite   (out_regwrite),
    .out_destreg    (out_destreg),
    .out_rs         (out_rs),
    .out_rt         (out_rt),
    .out_alucontrol (out_alucontrol),
    .out_illegal    (out_illegal),
    .mult_busy      (mult_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // {memtoreg,memwrite,alusrcbimm,jump,jr,beq,bltz, regwrite, destreg, alucontrol, illegal}
  function automatic logic [18:0] observed();
    return {out_memtoreg, out_memwrite, out_alusrcbimm, out_jump, out_jr, out_beq, out_bltz,
            out_regwrite, out_destreg, out_alucontrol, out_illegal};
  endfunction

  logic [31:0] vec_instr [12];
  logic [18:0] vec_exp   [12];

  initial begin
    int busy_cycles;
    int ready_k;
    int mflo_k;

    vec_instr[0]  = 32'h0C00_0010;                      // jal
    vec_exp[0]    = {7'b0001000, 2'b10, 5'd31, 4'hF, 1'b0};
    vec_instr[1]  = itype(6'h2B, 5'd3, 5'd2, 16'd8);    // sw $2,8($3)
    vec_exp[1]    = {7'b0110000, 2'b00, 5'd2, 4'h2, 1'b0};
    vec_instr[2]  = itype(6'h04, 5'd1, 5'd2, 16'd4);    // beq $1,$2
    vec_exp[2]    = {7'b0000010, 2'b00, 5'd2, 4'h6, 1'b0};
    vec_instr[3]  = itype(6'h01, 5'd4, 5'd0, 16'd4);    // bltz $4
    vec_exp[3]    = {7'b0000001, 2'b00, 5'd0, 4'hE, 1'b0};
    vec_instr[4]  = itype(6'h0F, 5'd0, 5'd7, 16'hABCD); // lui $7
    vec_exp[4]    = {7'b0010000, 2'b01, 5'd7, 4'h8, 1'b0};
    vec_instr[5]  = rtype(5'd31, 5'd0, 5'd0, 6'h08);    // jr $31
    vec_exp[5]    = {7'b0000100, 2'b00, 5'd0, 4'hF, 1'b0};
    vec_instr[6]  = rtype(5'd5, 5'd6, 5'd4, 6'h23);     // subu $4,$5,$6
    vec_exp[6]    = {7'b0000000, 2'b01, 5'd4, 4'h6, 1'b0};
    vec_instr[7]  = rtype(5'd9, 5'd10, 5'd8, 6'h2B);    // sltu $8,$9,$10
    vec_exp[7]    = {7'b0000000, 2'b01, 5'd8, 4'hE, 1'b0};
    vec_instr[8]  = itype(6'h09, 5'd0, 5'd3, 16'd1);    // addiu $3,$0,1
    vec_exp[8]    = {7'b0010000, 2'b01, 5'd3, 4'h2, 1'b0};
    vec_instr[9]  = rtype(5'd2, 5'd3, 5'd1, 6'h24);     // and $1,$2,$3
    vec_exp[9]    = {7'b0000000, 2'b01, 5'd1, 4'h0, 1'b0};
    vec_instr[10] = rtype(5'd2, 5'd3, 5'd1, 6'h25);     // or $1,$2,$3
    vec_exp[10]   = {7'b0000000, 2'b01, 5'd1, 4'h1, 1'b0};
    vec_instr[11] = rtype(5'd0, 5'd0, 5'd2, 6'h10);     // mfhi $2
    vec_exp[11]   = {7'b0000000, 2'b01, 5'd2, 4'hC, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", mult_busy, 0);
    check("rst_alu", out_alucontrol, 4'hF);
    check("rst_fields", observed(), {7'b0, 2'b00, 5'd0, 4'hF, 1'b0});
    reset_n = 1'b1;
    #1;
    check("rel_ready", in_ready, 1);

    // Scenario 1: addu $3,$1,$2
    in_instr  = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("s1_valid", out_valid, 1);
    check("s1_alu", out_alucontrol, 4'b0010);
    check("s1_dest", out_destreg, 3);
    check("s1_rw", out_regwrite, 2'b01);
    check("s1_rsrt", {out_rs, out_rt}, {5'd1, 5'd2});
    tick();
    check("s1_drain", out_valid, 0);

    // Decode table, streamed back to back
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_instr = vec_instr[i];
      tick();
      check($sformatf("dec%0d_valid", i), out_valid, 1);
      check($sformatf("dec%0d", i), observed(), vec_exp[i]);
    end
    in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h3F);          // unknown funct
    tick();
    in_valid = 1'b0;
    check("badfn_ill", out_illegal, 1);
    check("badfn_ctl", {out_regwrite, out_jr, out_memwrite}, 0);
    tick();

    // Scenario 2: lw $5,0($4) then addu $6,$5,$1 -> one bubble
    in_instr = itype(6'h23, 5'd4, 5'd5, 16'd0);
    in_valid = 1'b1;
    tick();
    in_instr = rtype(5'd5, 5'd1, 5'd6, 6'h21);
    #1;
    check("s2_lw", observed(), {7'b1010000, 2'b01, 5'd5, 4'h2, 1'b0});
    check("s2_stall", in_ready, 0);
    tick();
    check("s2_bubble", out_valid, 0);
    check("s2_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("s2_addu", {out_valid, out_destreg}, {1'b1, 5'd6});
    tick();
    // Same pair with $0 as lw destination -> no stall, no bubble
    in_instr = itype(6'h23, 5'd4, 5'd0, 16'd0);
    in_valid = 1'b1;
    tick();
    in_instr = rtype(5'd0, 5'd1, 5'd6, 6'h21);
    #1;
    check("s2z_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("s2z_addu", {out_valid, out_destreg}, {1'b1, 5'd6});
    tick();

    // Scenario 3: mult then mflo, MULT_LAT=4
    in_instr = rtype(5'd1, 5'd2, 5'd0, 6'h18);
    in_valid = 1'b1;
    tick();
    in_instr = rtype(5'd0, 5'd0, 5'd7, 6'h12);
    #1;
    check("s3_mult", {out_valid, out_alucontrol, out_regwrite}, {1'b1, 4'b0111, 2'b00});
    check("s3_stall", in_ready, 0);
    busy_cycles = 0;
    ready_k     = 0;
    mflo_k      = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ready_k != 0) in_valid = 1'b0;
      if (mult_busy) busy_cycles++;
      if (out_valid && out_alucontrol == 4'b1010 && mflo_k == 0) mflo_k = k;
      if (in_ready && in_valid && ready_k == 0) ready_k = k;
    end
    check("s3_busy_cycles", busy_cycles, 4);
    check("s3_accept_cycle", ready_k, 5);
    check("s3_mflo_cycle", mflo_k, 6);

    // Scenario 4: backpressure for 3 cycles
    in_instr = itype(6'h0D, 5'd8, 5'd9, 16'h1234);      // ori $9,$8
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_instr = itype(6'h09, 5'd0, 5'd10, 16'd5);        // addiu $10,$0,5
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("s4_hold%0d", i), {out_valid, out_destreg, out_alucontrol, out_alusrcbimm},
            {1'b1, 5'd9, 4'b0001, 1'b1});
      check($sformatf("s4_ready%0d", i), in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("s4_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("s4_next", {out_valid, out_destreg, out_alucontrol}, {1'b1, 5'd10, 4'b0010});
    tick();

    // Scenario 5: flush with in_valid while the multiply counter runs
    in_instr = rtype(5'd1, 5'd2, 5'd0, 6'h18);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    check("s5_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("s5_drop", out_valid, 0);
    busy_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      if (mult_busy) busy_cycles++;
      tick();
    end
    check("s5_cnt_kept", busy_cycles, 3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    check("s5_flush_slot", out_valid, 0);

    // Scenario 6: illegal opcode, then reset mid-stall
    in_instr = 32'hFC00_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("s6_illegal", {out_valid, out_illegal}, 2'b11);
    check("s6_ctl", {out_regwrite, out_memwrite, out_memtoreg, out_jump, out_jr, out_beq, out_bltz}, 0);
    out_ready = 1'b1;
    tick();
    in_instr = rtype(5'd1, 5'd2, 5'd0, 6'h18);          // mult
    in_valid = 1'b1;
    tick();
    in_instr = itype(6'h23, 5'd4, 5'd5, 16'd0);         // lw $5
    tick();
    out_ready = 1'b0;
    in_instr  = rtype(5'd5, 5'd1, 5'd6, 6'h21);         // addu $6,$5,$1
    #1;
    check("s6_stall", {in_ready, mult_busy, out_memtoreg}, 3'b011);
    reset_n = 1'b0;
    #1;
    check("s6_rst_valid", out_valid, 0);
    check("s6_rst_busy", mult_busy, 0);
    check("s6_rst_fields", observed(), {7'b0, 2'b00, 5'd0, 4'hF, 1'b0});
    tick();
    reset_n = 1'b1;
    #1;
    check("s6_rel_ready", in_ready, 1);
    check("s6_rel_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("s6_after", {out_valid, out_destreg}, {1'b1, 5'd6});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
